// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute controller for the ALU datapath.
// Decodes ADDI/ADD/SUB/BNE, drives the register-file/ALU controls, resolves BNE
// from the datapath EQ flag, owns the PC and counts retired instructions.
module ctrl_sequencer #(
    parameter int unsigned            ADDRESS_WIDTH = 5,
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     instr_req,
    output logic [DATA_WIDTH-1:0]    instr_addr,
    input  logic [DATA_WIDTH-1:0]    instr_rdata,
    input  logic                     instr_valid,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic                     ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic [DATA_WIDTH-1:0]    instret,
    output logic                     illegal
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_TRAP   = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [DATA_WIDTH-1:0]   ir, ir_d;
    logic                    branch_q, branch_d;

    logic                    req_d;
    logic                    regwrite_d;
    logic                    alusrc_d;
    logic                    aluctrl_d;
    logic [DATA_WIDTH-1:0]   imm_d;
    logic [ADDRESS_WIDTH-1:0] rs1_d, rs2_d, rd_d;
    logic [DATA_WIDTH-1:0]   pc_d;
    logic [DATA_WIDTH-1:0]   instret_d;
    logic                    illegal_d;

    // Instruction fields of the held instruction
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [ADDRESS_WIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [DATA_WIDTH-1:0]   imm_i, imm_b;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign funct7  = ir[31:25];
    assign dec_rs1 = ADDRESS_WIDTH'(ir[19:15]);
    assign dec_rs2 = ADDRESS_WIDTH'(ir[24:20]);
    assign dec_rd  = ADDRESS_WIDTH'(ir[11:7]);
    assign imm_i   = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_b   = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    // Fetch address is always the architectural PC
    assign instr_addr = pc;

    logic                    dec_legal;
    logic                    dec_write;
    logic                    dec_branch;
    logic                    dec_alusrc;
    logic                    dec_aluctrl;
    logic                    dec_has_imm;
    logic [DATA_WIDTH-1:0]   dec_imm;

    // Instruction decoder for the supported RV32I subset
    always_comb begin
        dec_legal   = 1'b0;
        dec_write   = 1'b0;
        dec_branch  = 1'b0;
        dec_alusrc  = 1'b0;
        dec_aluctrl = 1'b0;
        dec_has_imm = 1'b0;
        dec_imm     = '0;
        case (opcode)
            OPC_OPIMM: begin
                if (funct3 == F3_ADD) begin
                    dec_legal   = 1'b1;
                    dec_write   = 1'b1;
                    dec_alusrc  = 1'b1;
                    dec_has_imm = 1'b1;
                    dec_imm     = imm_i;
                end
            end
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    dec_legal   = 1'b1;
                    dec_write   = 1'b1;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    dec_legal   = 1'b1;
                    dec_write   = 1'b1;
                    dec_aluctrl = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BNE) begin
                    dec_legal   = 1'b1;
                    dec_branch  = 1'b1;
                    dec_aluctrl = 1'b1;
                    dec_has_imm = 1'b1;
                    dec_imm     = imm_b;
                end
            end
            default: ;
        endcase
    end

    logic [DATA_WIDTH-1:0] branch_target;
    assign branch_target = pc + immOp;

    // Next-state and next-output logic; everything holds unless a state acts on it
    always_comb begin
        state_d    = state;
        ir_d       = ir;
        branch_d   = branch_q;
        regwrite_d = 1'b0;
        alusrc_d   = ALUsrc;
        aluctrl_d  = ALUctrl;
        imm_d      = immOp;
        rs1_d      = rs1;
        rs2_d      = rs2;
        rd_d       = rd;
        pc_d       = pc;
        instret_d  = instret;
        illegal_d  = illegal;
        case (state)
            S_FETCH: begin
                if (instr_req && instr_valid) begin
                    ir_d    = instr_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    alusrc_d   = dec_alusrc;
                    aluctrl_d  = dec_aluctrl;
                    if (dec_has_imm) begin
                        imm_d = dec_imm;
                    end
                    rs1_d      = dec_rs1;
                    rs2_d      = dec_rs2;
                    rd_d       = dec_rd;
                    regwrite_d = dec_write && (dec_rd != '0);
                    branch_d   = dec_branch;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (branch_q && !EQ) begin
                    // Halfword-misaligned target cannot be fetched: trap without retiring
                    if (branch_target[1]) begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end else begin
                        pc_d      = branch_target;
                        instret_d = instret + DATA_WIDTH'(1);
                        state_d   = S_FETCH;
                    end
                end else begin
                    pc_d      = pc + DATA_WIDTH'(PC_STEP);
                    instret_d = instret + DATA_WIDTH'(1);
                    state_d   = S_FETCH;
                end
            end
            S_TRAP: begin
                illegal_d = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        req_d = (state_d == S_FETCH);
    end

    // State and registered outputs; synchronous reset aborts any instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ir        <= '0;
            branch_q  <= 1'b0;
            instr_req <= 1'b0;
            RegWrite  <= 1'b0;
            ALUsrc    <= 1'b0;
            ALUctrl   <= 1'b0;
            immOp     <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            pc        <= RESET_PC;
            instret   <= '0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_d;
            ir        <= ir_d;
            branch_q  <= branch_d;
            instr_req <= req_d;
            RegWrite  <= regwrite_d;
            ALUsrc    <= alusrc_d;
            ALUctrl   <= aluctrl_d;
            immOp     <= imm_d;
            rs1       <= rs1_d;
            rs2       <= rs2_d;
            rd        <= rd_d;
            pc        <= pc_d;
            instret   <= instret_d;
            illegal   <= illegal_d;
        end
    end

endmodule
